// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word/strobe constants.
// The verify states exist only when INSTR_LOADER_VERIFY_EN is defined.
package instr_loader_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WE_ALL     = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COLLECT    = 3'd1,
    S_WRITE      = 3'd2,
`ifdef INSTR_LOADER_VERIFY_EN
    S_VERIFY_RD  = 3'd3,
    S_VERIFY_CMP = 3'd4,
    S_ERROR      = 3'd6,
`endif
    S_DONE       = 3'd5
  } state_t;

  function automatic logic is_busy(state_t s);
    case (s)
      S_COLLECT, S_WRITE: return 1'b1;
`ifdef INSTR_LOADER_VERIFY_EN
      S_VERIFY_RD, S_VERIFY_CMP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // A new load may only be launched from a resting state.
  function automatic logic can_start(state_t s);
    case (s)
      S_IDLE, S_DONE: return 1'b1;
`ifdef INSTR_LOADER_VERIFY_EN
      S_ERROR: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Debug write/read port into the instruction memory.
// master = loader side, slave = memory side.
interface instr_mem_loader_if;
  logic [31:0] A2;
  logic [31:0] WD2;
  logic [3:0]  WE2;
  logic [31:0] RD2;

  modport master (output A2, output WD2, output WE2, input RD2);
  modport slave  (input A2, input WD2, input WE2, output RD2);
endinterface

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; word_valid flags the transfer of the last byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] cnt;

  assign word_valid = take && (cnt == 2'(WORD_BYTES - 1));

  // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (take) begin
      cnt  <= cnt + 2'd1;
      word <= {byte_in, word[31:8]};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory via the debug port, one 32-bit word at a time.
// Define INSTR_LOADER_VERIFY_EN to read back and compare every word after it is written.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  instr_mem_loader_if.master        dbg,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               word_idx
);

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  state_t      state, state_n;
  logic [31:0] a2_q;
  logic [3:0]  we_q;
  logic [31:0] word;
  logic        word_valid;
  logic        take;
  logic        start_ok;
  logic        last;
  logic        commit;

  assign take     = byte_valid && byte_ready && !abort;
  assign start_ok = start && !abort && can_start(state);
  assign last     = (word_idx == LAST_IDX);

  assign dbg.A2  = a2_q;
  assign dbg.WD2 = word;
  assign dbg.WE2 = we_q;

`ifdef INSTR_LOADER_VERIFY_EN
  logic match;
  assign match  = (dbg.RD2 == word);
  assign commit = !abort && (state == S_VERIFY_CMP) && match;
`else
  logic unused_rd;
  assign unused_rd = ^dbg.RD2;
  assign commit    = !abort && (state == S_WRITE);
  assign error     = 1'b0;
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (abort || start_ok),
    .take       (take),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_COLLECT: if (word_valid) state_n = S_WRITE;
`ifdef INSTR_LOADER_VERIFY_EN
        S_WRITE:      state_n = S_VERIFY_RD;
        S_VERIFY_RD:  state_n = S_VERIFY_CMP;
        S_VERIFY_CMP: state_n = !match ? S_ERROR : (last ? S_DONE : S_COLLECT);
`else
        S_WRITE:      state_n = last ? S_DONE : S_COLLECT;
`endif
        default: if (start_ok) state_n = S_COLLECT;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      we_q       <= 4'h0;
      a2_q       <= BASE_ADDR;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_idx   <= 16'd0;
`ifdef INSTR_LOADER_VERIFY_EN
      error      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      byte_ready <= (state_n == S_COLLECT);
      we_q       <= (state_n == S_WRITE) ? WE_ALL : 4'h0;
      busy       <= is_busy(state_n);
      done       <= (state_n == S_DONE);
`ifdef INSTR_LOADER_VERIFY_EN
      error      <= (state_n == S_ERROR);
`endif
      if (start_ok) begin
        word_idx <= 16'd0;
        a2_q     <= BASE_ADDR;
      end else if (commit) begin
        word_idx <= word_idx + 16'd1;
        a2_q     <= a2_q + 32'(WORD_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: two instances (base 0 and base 0xFFFF_FFFC, two words each).
// Extra readback-corruption check when built with INSTR_LOADER_VERIFY_EN.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;

  logic        br0, br1, busy0, busy1, done0, done1, err0, err1;
  logic [15:0] widx0, widx1;
  logic [31:0] rd0, rd1;
  bit          corrupt0 = 1'b0;

  instr_mem_loader_if mif0();
  instr_mem_loader_if mif1();

  assign mif0.RD2 = rd0;
  assign mif1.RD2 = rd1;

  instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .WORD_COUNT(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br0),
    .dbg(mif0), .busy(busy0), .done(done0), .error(err0), .word_idx(widx0)
  );

  instr_mem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .WORD_COUNT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(br1),
    .dbg(mif1), .busy(busy1), .done(done1), .error(err1), .word_idx(widx1)
  );

  always #5 clk = ~clk;

  // Memory models with write logs; read data is registered one cycle after the address.
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] wa0 [256], wd0 [256], wa1 [256], wd1 [256];
  logic [3:0]  we0 [256], we1 [256];
  int wc0 = 0, wc1 = 0;

  always @(posedge clk) begin
    if (mif0.WE2 != 4'h0) begin
      wa0[wc0 & 255] = mif0.A2; wd0[wc0 & 255] = mif0.WD2; we0[wc0 & 255] = mif0.WE2;
      if (mif0.WE2 == 4'hF) mem0[mif0.A2] = mif0.WD2;
      wc0++;
    end
    if (mif1.WE2 != 4'h0) begin
      wa1[wc1 & 255] = mif1.A2; wd1[wc1 & 255] = mif1.WD2; we1[wc1 & 255] = mif1.WE2;
      if (mif1.WE2 == 4'hF) mem1[mif1.A2] = mif1.WD2;
      wc1++;
    end
    if (mem0.exists(mif0.A2))
      rd0 <= mem0[mif0.A2] ^ ((corrupt0 && mif0.A2 == 32'h4) ? 32'h1 : 32'h0);
    else
      rd0 <= 32'h0;
    rd1 <= mem1.exists(mif1.A2) ? mem1[mif1.A2] : 32'h0;
  end

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3, b4, b5, b6, b7;
    logic        stall;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t vecs [4];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stall);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!br0 && t < 20) begin tick(); t++; end
    if (!br0) chk("byte_ready timeout", {31'd0, br0}, 32'd1);
    tick();
    byte_valid = 1'b0;
    if (stall) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input logic stall);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done0 && t < 60) begin tick(); t++; end
    chk("done timeout", {31'd0, done0}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " byte_ready0"}, {31'd0, br0}, 32'd0);
    chk({tag, " WE2_0"}, {28'd0, mif0.WE2}, 32'd0);
    chk({tag, " A2_0"}, mif0.A2, 32'h0000_0000);
    chk({tag, " A2_1"}, mif1.A2, 32'hFFFF_FFFC);
    chk({tag, " WD2_0"}, mif0.WD2, 32'd0);
    chk({tag, " busy/done/error"}, {29'd0, busy0, done0, err0}, 32'd0);
    chk({tag, " word_idx0"}, {16'd0, widx0}, 32'd0);
  endtask

  // Checks the two writes logged from index b0/b1 onward for both instances.
  task automatic chk_two_writes(input string tag, input int b0, input int b1,
                                input logic [31:0] x0, input logic [31:0] x1);
    chk({tag, " write count0"}, 32'(wc0 - b0), 32'd2);
    chk({tag, " write count1"}, 32'(wc1 - b1), 32'd2);
    chk({tag, " addr0 w0"}, wa0[b0 & 255], 32'h0000_0000);
    chk({tag, " data0 w0"}, wd0[b0 & 255], x0);
    chk({tag, " addr0 w1"}, wa0[(b0 + 1) & 255], 32'h0000_0004);
    chk({tag, " data0 w1"}, wd0[(b0 + 1) & 255], x1);
    chk({tag, " strobe0"}, {24'd0, we0[b0 & 255], we0[(b0 + 1) & 255]}, 32'h0000_00FF);
    chk({tag, " addr1 w0"}, wa1[b1 & 255], 32'hFFFF_FFFC);
    chk({tag, " addr1 w1"}, wa1[(b1 + 1) & 255], 32'h0000_0000);
    chk({tag, " data1 w1"}, wd1[(b1 + 1) & 255], x1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;

    vecs[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 1'b0, 32'h0000_0013, 32'h0010_0093};
    vecs[1] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 1'b1, 32'h0000_0013, 32'h0010_0093};
    vecs[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 32'hDEAD_BEEF, 32'h0403_0201};
    vecs[3] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    #1;
    chk_reset_outputs("por");
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      logic [7:0] bs [8];
      string tag;
      tag = $sformatf("vec%0d", i);
      bs = '{vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3,
             vecs[i].b4, vecs[i].b5, vecs[i].b6, vecs[i].b7};
      b0 = wc0; b1 = wc1;
      start_load();
      chk({tag, " busy after start"}, {30'd0, busy0, br0}, 32'd3);
      for (int k = 0; k < 8; k++) send_byte(bs[k], vecs[i].stall);
      wait_done();
      tick();
      chk_two_writes(tag, b0, b1, vecs[i].w0, vecs[i].w1);
      chk({tag, " done1"}, {31'd0, done1}, 32'd1);
      chk({tag, " word_idx"}, {widx0, widx1}, {16'd2, 16'd2});
      chk({tag, " busy/ready/error"}, {29'd0, busy0, br0, err0}, 32'd0);
    end

    // Abort after two bytes of word 1; the next load must start clean.
    b0 = wc0;
    start_load();
    send_word(32'hCAFE_F00D, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    byte_in = 8'h77; byte_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    chk("abort busy/ready/done", {29'd0, busy0, br0, done0}, 32'd0);
    chk("abort dut1 busy", {31'd0, busy1}, 32'd0);
    repeat (6) tick();
    chk("abort write count", 32'(wc0 - b0), 32'd1);
    chk("abort word0 data", wd0[b0 & 255], 32'hCAFE_F00D);
    b0 = wc0; b1 = wc1;
    start_load();
    for (int k = 0; k < 8; k++) send_byte(8'(8'h11 + k), 1'b0);
    wait_done();
    tick();
    chk_two_writes("post-abort", b0, b1, 32'h1413_1211, 32'h1817_1615);

    // Reset asserted while the last byte of word 1 is being offered.
    b0 = wc0;
    start_load();
    send_word(32'h0BAD_F00D, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    byte_in = 8'hA4; byte_valid = 1'b1; rst = 1'b1;
    #1;
    chk_reset_outputs("midload rst");
    #1;
    rst = 1'b0; byte_valid = 1'b0;
    repeat (5) tick();
    chk("rst no extra write", 32'(wc0 - b0), 32'd1);
    chk("rst idle", {29'd0, busy0, br0, done0}, 32'd0);
    b0 = wc0; b1 = wc1;
    start_load();
    send_word(32'hA3A2_A1A0, 1'b0);
    send_word(32'hB3B2_B1B0, 1'b1);
    wait_done();
    tick();
    chk_two_writes("post-rst", b0, b1, 32'hA3A2_A1A0, 32'hB3B2_B1B0);

`ifdef INSTR_LOADER_VERIFY_EN
    // Corrupt readback of 0x4 on instance 0 only.
    begin
      int t = 0;
      corrupt0 = 1'b1;
      start_load();
      send_word(32'h0000_0013, 1'b0);
      send_word(32'h0010_0093, 1'b0);
      while (!err0 && t < 60) begin tick(); t++; end
      chk("verify error", {31'd0, err0}, 32'd1);
      chk("verify A2 held", mif0.A2, 32'h0000_0004);
      chk("verify done0", {31'd0, done0}, 32'd0);
      chk("verify clean done1", {30'd0, done1, err1}, 32'd2);
      corrupt0 = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written; SHALL be word-aligned.
REQ-002 Parameter WORD_COUNT, default 1024, number of 32-bit words per load; range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a load.
REQ-006 abort  in  1  one-cycle request to cancel a load.
REQ-007 byte_in  in  8  stream data byte, little-endian within a word.
REQ-008 byte_valid  in  1  byte_in is valid.
REQ-009 byte_ready  out  1  loader accepts byte_in this cycle.
REQ-010 A2  out  32  debug-port byte address into instruction memory.
REQ-011 WD2  out  32  debug-port write data.
REQ-012 WE2  out  4  debug-port byte write enables.
REQ-013 RD2  in  32  debug-port read data, valid one cycle after the address is presented.
REQ-014 busy / done / error  out  1 each  load active / load completed / verify mismatch, held as levels.
REQ-015 word_idx  out  16  number of words committed in the current load.

Function
REQ-016 States: IDLE, COLLECT, WRITE, VERIFY_RD, VERIFY_CMP, DONE, ERROR.
REQ-017 start in IDLE, DONE or ERROR SHALL clear word_idx, done, error and the byte counter, then enter COLLECT. start in any other state SHALL be ignored.
REQ-018 byte_ready SHALL be 1 only in COLLECT. A byte transfers when byte_valid and byte_ready are both 1 on a clock edge.
REQ-019 Byte k (0..3) of a word SHALL land in WD2[8k+7:8k]. The transfer of byte 3 SHALL move the FSM to WRITE on the next edge.
REQ-020 WRITE SHALL last exactly one cycle, with A2 = BASE_ADDR + 4*word_idx, WD2 = the assembled word and WE2 = 4'hF.
REQ-021 In every state other than WRITE, WE2 SHALL be 4'h0.
REQ-022 word_idx SHALL increment on leaving WRITE (or VERIFY_CMP when verify is enabled), then:
  - if word_idx equals WORD_COUNT, go to DONE;
  - otherwise go to COLLECT.
REQ-023 busy SHALL equal 1 in COLLECT, WRITE, VERIFY_RD and VERIFY_CMP.
REQ-024 abort SHALL return the FSM to IDLE on the next edge from any state and discard any partial word. It has priority over start and over a byte transfer in the same cycle. If abort coincides with WRITE, that write still completes.
REQ-025 A2 SHALL increment by 4 per word with 32-bit wrap-around; wrap is not flagged.

Reset
REQ-026 On rst: state IDLE; byte_ready=0, WE2=0, A2=BASE_ADDR, WD2=0; busy, done and error = 0; word_idx=0.
REQ-027 rst asserted mid-load SHALL abandon the load with no further write pulse.

Configuration
REQ-028 Macro INSTR_LOADER_VERIFY_EN defined:
  - WRITE goes to VERIFY_RD, which presents the same A2 with WE2=0 for one cycle.
  - VERIFY_CMP then compares RD2 against the written word.
  - On match, proceed per REQ-022.
  - On mismatch, go to ERROR with error=1 and A2 held at the failing address.
REQ-029 Macro undefined: VERIFY_RD, VERIFY_CMP and ERROR are absent, error is tied to 0, and write throughput is one word per 5 cycles at full byte rate.

Structure
REQ-030 Shared package instr_loader_pkg SHALL hold the state encoding, WORD_BYTES=4 and WE_ALL=4'hF.
REQ-031 Byte assembly SHALL be a sub-module byte_packer, with a 2-bit counter, a 32-bit shift register and a word_valid pulse output.

Verification
REQ-032 Write path, WORD_COUNT=2: start, then bytes 13,00,00,00,93,00,10,00 → writes of 32'h0000_0013 @0x0 and 32'h0010_0093 @0x4, then done=1 and word_idx=2.
REQ-033 Byte stalls: byte_valid toggles every other cycle → identical memory contents, with exactly one WE2 pulse per word.
REQ-034 Abort: abort after 2 bytes of word 1 → IDLE next cycle, no write for word 1, busy=0, byte_ready=0.
REQ-035 Reset: rst pulsed during WRITE-bound COLLECT → all outputs at REQ-026 values within the same cycle; a following start loads from BASE_ADDR.
REQ-036 Verify, with INSTR_LOADER_VERIFY_EN: memory model corrupts word @0x4 → error=1, A2=0x4, done=0. With a clean model → done=1.
REQ-037 Boundary: BASE_ADDR=32'hFFFF_FFFC, WORD_COUNT=2 → writes @0xFFFF_FFFC then @0x0000_0000, then done=1.
